pb_event_scheduler: RTL



---
 rtl/pb_sched_pkg.sv | 20 ++
 rtl/pb_press_timer.sv | 39 +++
 rtl/pb_event_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pb_sched_pkg.sv
// Shared types and helpers for the push-button event scheduler.
package pb_sched_pkg;

  // Output channel state: nothing offered, or an event held on the channel.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_e;

  // Width needed to index n buttons (at least one bit).
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Round-robin successor of idx among n buttons, wrapping n-1 -> 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pb_press_timer.sv
// Per-button press timer: detects the release edge of a debounced level and
// reports whether the press that just ended was held long enough to be long.
module pb_press_timer #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_level,
  output logic rel_pulse,
  output logic long_flag
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

  logic          prev_q;
  logic [CW-1:0] count_q;

  // Track the previous level and count held cycles, saturating at the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q <= pb_level;
      if (!pb_level) begin
        count_q <= '0;
      end else if (count_q != HOLD_MAX) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  // Release is seen combinationally on the first low sample; the count still
  // holds the number of high samples that preceded it.
  assign rel_pulse = prev_q & ~pb_level;
  assign long_flag = (count_q >= HOLD_MAX);

endmodule

// File: rtl/pb_event_scheduler.sv
// Collects short/long release events from NUM_PB buttons into one-deep
// pending slots and offers them round-robin on a valid/ready channel.
//
// Handshake: an event transfers on a rising edge where evt_valid and
// evt_ready are both high; while evt_valid is high and evt_ready is low,
// evt_id and evt_long stay unchanged; evt_valid never drops without a transfer
// except on reset.
module pb_event_scheduler
  import pb_sched_pkg::*;
#(
  parameter  int NUM_PB      = 4,
  parameter  int HOLD_CYCLES = 1000,
  localparam int IDW         = id_width(NUM_PB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PB-1:0] pb_level,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [IDW-1:0]    evt_id,
  output logic              evt_long,
  output logic [NUM_PB-1:0] pending,
  output logic              overrun
);

  logic [NUM_PB-1:0] rel;
  logic [NUM_PB-1:0] rel_long;
  logic [NUM_PB-1:0] pend_long_q;
  logic [NUM_PB-1:0] grant_oh;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    win_id;
  logic              win_found;
  logic              do_grant;
  sched_state_e      state_q;

  for (genvar g = 0; g < NUM_PB; g++) begin : g_timer
    pb_press_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .pb_level (pb_level[g]),
      .rel_pulse(rel[g]),
      .long_flag(rel_long[g])
    );
  end

  // Round-robin search over the pending slots starting at rr_ptr_q.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_PB; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_PB) idx = idx - NUM_PB;
      if (!win_found && pending[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // A slot is granted when the channel is free now or frees on this edge.
  assign do_grant = win_found && ((state_q == IDLE) || evt_ready);
  assign grant_oh = do_grant ? (NUM_PB'(1) << win_id) : '0;

  // Pending slots: granted slot clears, a release (re)fills; a release onto a
  // slot that survives this edge occupied is an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      pend_long_q <= '0;
      overrun     <= 1'b0;
    end else begin
      pending     <= (pending & ~grant_oh) | rel;
      pend_long_q <= (pend_long_q & ~rel) | (rel_long & rel);
      if (|(rel & pending & ~grant_oh)) overrun <= 1'b1;
    end
  end

  // Output FSM with registered channel outputs and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_long  <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (do_grant) begin
            evt_valid <= 1'b1;
            evt_id    <= win_id;
            evt_long  <= pend_long_q[win_id];
            rr_ptr_q  <= IDW'(rr_next(int'(win_id), NUM_PB));
            state_q   <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            if (do_grant) begin
              evt_id   <= win_id;
              evt_long <= pend_long_q[win_id];
              rr_ptr_q <= IDW'(rr_next(int'(win_id), NUM_PB));
            end else begin
              evt_valid <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
